// File: rtl/calc_disp_scan_if.sv
// Core-to-display bundle: digit stream from the calculator core and the
// multiplexed 7-segment drive returned towards the board.
interface calc_disp_scan_if;
    // Stream protocol: there is no valid/ready pair. Every clock the core presents
    // one digit; pos 0..7 is a write of data to that slot, pos 8 closes the sweep
    // (commit if all eight slots were written), and pos 9..15 are ignored. The
    // display side never stalls the core.
    logic [3:0] data;
    logic [3:0] pos;
    logic [1:0] status;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_valid;

    modport master (
        output data, pos, status,
        input  an, seg, dp, frame_valid
    );

    modport slave (
        input  data, pos, status,
        output an, seg, dp, frame_valid
    );
endinterface

// File: rtl/calc_disp_scan.sv
// Frame capture, leading-zero blanking and 8-digit common-anode scan for the
// calculator display. Optional macro CALC_DISP_ERR_BLINK_EN makes "Err" blink.
module calc_disp_scan #(
    parameter int REFRESH_DIV = 50000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic              clock,
    input  logic              reset,
    calc_disp_scan_if.slave   core
);

    localparam int RW = $clog2(REFRESH_DIV);
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_R     = 7'h2F;

    if (REFRESH_DIV < 2) begin : g_bad_refresh
        $error("calc_disp_scan: REFRESH_DIV must be >= 2");
    end
    if (BLINK_DIV < 1) begin : g_bad_blink
        $error("calc_disp_scan: BLINK_DIV must be >= 1");
    end

    logic [3:0]    shadow [8];
    logic [3:0]    frame  [8];
    logic [7:0]    mask;
    logic          frame_valid_q;
    logic [RW-1:0] refresh_cnt;
    logic [2:0]    scan;
    logic [2:0]    msd;

    logic [7:0]    an_q,  an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q,  dp_d;

    logic pos_digit;
    logic pos_idle;
    logic commit;
    logic is_err;
    logic is_busy;
    logic blink_off;

    assign pos_digit = (core.pos <= 4'd7);
    assign pos_idle  = (core.pos == 4'd8);
    assign commit    = pos_idle && (mask == 8'hFF);
    assign is_err    = (core.status == 2'b00);
    assign is_busy   = (core.status == 2'b01);

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    // Shadow collects the sweep in progress; the mask records which slots were
    // written so a sweep with a skipped position never reaches the frame buffer.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) begin
                shadow[i] <= 4'd0;
            end
            mask <= 8'h00;
        end else if (pos_digit) begin
            shadow[core.pos[2:0]] <= core.data;
            mask[core.pos[2:0]]   <= 1'b1;
        end else if (pos_idle) begin
            mask <= 8'h00;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) begin
                frame[i] <= 4'd0;
            end
            frame_valid_q <= 1'b0;
        end else if (commit) begin
            for (int i = 0; i < 8; i++) begin
                frame[i] <= shadow[i];
            end
            frame_valid_q <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            refresh_cnt <= '0;
            scan        <= 3'd0;
        end else if (refresh_cnt == REFRESH_LAST) begin
            refresh_cnt <= '0;
            scan        <= scan + 3'd1;
        end else begin
            refresh_cnt <= refresh_cnt + RW'(1);
        end
    end

`ifdef CALC_DISP_ERR_BLINK_EN
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [BW-1:0] blink_cnt;
    logic          blink_phase;

    // The blink restarts from the lit phase each time the core enters error.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (!is_err) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + BW'(1);
        end
    end

    assign blink_off = is_err && blink_phase;
`else
    assign blink_off = 1'b0;
`endif

    always_comb begin
        msd = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (frame[i] != 4'd0) begin
                msd = 3'(i);
            end
        end
    end

    // Until the first frame lands the display stays fully dark, error included.
    always_comb begin
        an_d  = 8'hFF;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        if (frame_valid_q) begin
            an_d = ~(8'h01 << scan);
            if (is_err) begin
                if (scan == 3'd2) begin
                    seg_d = SEG_E;
                end else if (scan < 3'd2) begin
                    seg_d = SEG_R;
                end
            end else if (scan <= msd) begin
                seg_d = seg_of(frame[scan]);
            end
            if (is_busy && (scan == 3'd0)) begin
                dp_d = 1'b0;
            end
            if (blink_off) begin
                an_d = 8'hFF;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            an_q  <= 8'hFF;
            seg_q <= SEG_BLANK;
            dp_q  <= 1'b1;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    assign core.an          = an_q;
    assign core.seg         = seg_q;
    assign core.dp          = dp_q;
    assign core.frame_valid = frame_valid_q;

endmodule
